// File: rtl/calc_pkg.sv
// Shared definitions for the calculator's ASCII front/back ends.
// Holds the character constants, the state encoding of the result
// writer and a small digit-to-ASCII helper. The input-side ASCII
// converters import the same package.
package calc_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_HASH  = 8'h23;

  localparam logic [3:0] ST_ENC_IDLE      = 4'd0;
  localparam logic [3:0] ST_ENC_CONV_H    = 4'd1;
  localparam logic [3:0] ST_ENC_CONV_T    = 4'd2;
  localparam logic [3:0] ST_ENC_EMIT_SIGN = 4'd3;
  localparam logic [3:0] ST_ENC_EMIT_H    = 4'd4;
  localparam logic [3:0] ST_ENC_EMIT_T    = 4'd5;
  localparam logic [3:0] ST_ENC_EMIT_U    = 4'd6;
  localparam logic [3:0] ST_ENC_EMIT_TERM = 4'd7;
  localparam logic [3:0] ST_ENC_DONE      = 4'd8;

  typedef enum logic [3:0] {
    ST_IDLE      = ST_ENC_IDLE,
    ST_CONV_H    = ST_ENC_CONV_H,
    ST_CONV_T    = ST_ENC_CONV_T,
    ST_EMIT_SIGN = ST_ENC_EMIT_SIGN,
    ST_EMIT_H    = ST_ENC_EMIT_H,
    ST_EMIT_T    = ST_ENC_EMIT_T,
    ST_EMIT_U    = ST_ENC_EMIT_U,
    ST_EMIT_TERM = ST_ENC_EMIT_TERM,
    ST_DONE      = ST_ENC_DONE
  } wr_state_t;

  // Decimal digit 0..9 to its ASCII character.
  function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
    return ASCII_ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/result_ascii_writer.sv
// result_ascii_writer
// Turns a finished 8-bit calculator result into an ASCII character
// stream: optional '-', decimal digits without leading zeros, then a
// terminator. Digits come from a sequential subtract-100 / subtract-10
// loop; characters leave one per valid/ready transfer.
//
// Ports:
//   clk        rising-edge system clock
//   rst        asynchronous active-high reset
//   start      conversion request, only honoured in IDLE
//   value      result to print, latched on the accepted start
//   busy       high in every state except IDLE
//   done       one-cycle pulse after the terminator was transferred
//   char_out   character on offer, held while char_valid && !char_ready
//   char_valid char_out holds a character to transfer
//   char_ready downstream accepts the offered character
module result_ascii_writer
  import calc_pkg::*;
#(
  parameter bit         SIGNED_MODE = 1'b0,
  parameter logic [7:0] TERM_CHAR   = ASCII_HASH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] value,
  output logic       busy,
  output logic       done,
  output logic [7:0] char_out,
  output logic       char_valid,
  input  logic       char_ready
);

  wr_state_t  state;
  logic       neg;
  logic [7:0] mag;
  logic [1:0] hund;
  logic [3:0] tens;
  logic [3:0] units;

  logic       start_neg;
  logic [7:0] start_mag;
  logic       xfer;

  // Sign and magnitude of the incoming value; -128 wraps to a
  // magnitude of 128, which the 8-bit unsigned loop handles fine.
  assign start_neg = SIGNED_MODE & value[7];
  assign start_mag = start_neg ? (~value + 8'd1) : value;
  assign xfer      = char_valid & char_ready;

  // First digit that survives leading-zero suppression.
  function automatic wr_state_t lead_state(input logic [1:0] h,
                                           input logic [3:0] t);
    if (h != 2'd0) return ST_EMIT_H;
    else if (t != 4'd0) return ST_EMIT_T;
    else return ST_EMIT_U;
  endfunction

  function automatic logic [7:0] lead_char(input logic [1:0] h,
                                           input logic [3:0] t,
                                           input logic [3:0] u);
    if (h != 2'd0) return digit_to_ascii({2'b00, h});
    else if (t != 4'd0) return digit_to_ascii(t);
    else return digit_to_ascii(u);
  endfunction

  // Whole controller: conversion loop, emit sequencing and the
  // registered handshake outputs. Each emit state loads the next
  // character on its transfer edge so char_valid can stay high
  // back-to-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      char_valid <= 1'b0;
      char_out   <= 8'h00;
      neg        <= 1'b0;
      mag        <= 8'h00;
      hund       <= 2'd0;
      tens       <= 4'd0;
      units      <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            neg   <= start_neg;
            mag   <= start_mag;
            hund  <= 2'd0;
            tens  <= 4'd0;
            units <= 4'd0;
            busy  <= 1'b1;
            state <= ST_CONV_H;
          end
        end
        ST_CONV_H: begin
          if (mag >= 8'd100) begin
            mag  <= mag - 8'd100;
            hund <= hund + 2'd1;
          end else begin
            state <= ST_CONV_T;
          end
        end
        ST_CONV_T: begin
          if (mag >= 8'd10) begin
            mag  <= mag - 8'd10;
            tens <= tens + 4'd1;
          end else begin
            // mag is now the units digit; it is used directly because
            // the units register only updates on this same edge.
            units      <= mag[3:0];
            char_valid <= 1'b1;
            if (neg) begin
              state    <= ST_EMIT_SIGN;
              char_out <= ASCII_MINUS;
            end else begin
              state    <= lead_state(hund, tens);
              char_out <= lead_char(hund, tens, mag[3:0]);
            end
          end
        end
        ST_EMIT_SIGN: begin
          if (xfer) begin
            state    <= lead_state(hund, tens);
            char_out <= lead_char(hund, tens, units);
          end
        end
        ST_EMIT_H: begin
          if (xfer) begin
            state    <= ST_EMIT_T;
            char_out <= digit_to_ascii(tens);
          end
        end
        ST_EMIT_T: begin
          if (xfer) begin
            state    <= ST_EMIT_U;
            char_out <= digit_to_ascii(units);
          end
        end
        ST_EMIT_U: begin
          if (xfer) begin
            state    <= ST_EMIT_TERM;
            char_out <= TERM_CHAR;
          end
        end
        ST_EMIT_TERM: begin
          if (xfer) begin
            state      <= ST_DONE;
            char_valid <= 1'b0;
            char_out   <= 8'h00;
            done       <= 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state      <= ST_IDLE;
          busy       <= 1'b0;
          done       <= 1'b0;
          char_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_ascii_writer.sv
// Testbench for result_ascii_writer.
// Drives an unsigned and a signed instance with the same stimulus and
// checks both against a decimal-string model of the printed result.
module tb_result_ascii_writer;
  import calc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] value = 8'h00;
  logic       char_ready = 1'b0;

  logic [1:0] busy_w;
  logic [1:0] done_w;
  logic [1:0] valid_w;
  logic [7:0] char_w [2];

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];
  int         done_seen [2];
  logic       prev_pend [2];
  logic [7:0] prev_char [2];
  logic [7:0] mon_front;
  int         mon_size;

  result_ascii_writer #(.SIGNED_MODE(1'b0), .TERM_CHAR(8'h23)) dut_u (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy_w[0]), .done(done_w[0]), .char_out(char_w[0]),
    .char_valid(valid_w[0]), .char_ready(char_ready)
  );

  result_ascii_writer #(.SIGNED_MODE(1'b1), .TERM_CHAR(8'h23)) dut_s (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy_w[1]), .done(done_w[1]), .char_out(char_w[1]),
    .char_valid(valid_w[1]), .char_ready(char_ready)
  );

  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded loops.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkString(input string name, input string actual,
                             input string expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got \"%s\", expected \"%s\"", name, actual, expected);
    end
  endtask

  // Model: the printed text is simply the decimal rendering of the value.
  function automatic string model_string(input logic [7:0] v, input bit sgn);
    if (sgn && v[7]) return $sformatf("%0d", int'(v) - 256);
    else return $sformatf("%0d", int'(v));
  endfunction

  // Model: conversion spends one cycle per hundred, one per ten, plus two.
  function automatic int model_latency(input logic [7:0] v, input bit sgn);
    int m;
    m = (sgn && v[7]) ? 256 - int'(v) : int'(v);
    return m / 100 + (m % 100) / 10 + 2;
  endfunction

  task automatic loadModel(input logic [7:0] v);
    string su;
    string ss;
    su = model_string(v, 1'b0);
    ss = model_string(v, 1'b1);
    exp_q0.delete();
    exp_q1.delete();
    for (int k = 0; k < su.len(); k++) exp_q0.push_back(su[k]);
    for (int k = 0; k < ss.len(); k++) exp_q1.push_back(ss[k]);
    exp_q0.push_back(8'h23);
    exp_q1.push_back(8'h23);
  endtask

  // Stream checker: every offered character must match the model queue
  // head, stay put while stalled, and done must only follow the last one.
  always @(negedge clk) begin
    if (rst) begin
      prev_pend[0] = 1'b0;
      prev_pend[1] = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        mon_size = (i == 0) ? exp_q0.size() : exp_q1.size();
        if (prev_pend[i]) begin
          checkOutput(i == 0 ? "valid_held_u" : "valid_held_s", valid_w[i], 1);
          checkOutput(i == 0 ? "char_held_u" : "char_held_s", char_w[i], prev_char[i]);
        end
        if (valid_w[i]) begin
          if (mon_size == 0) begin
            checkOutput(i == 0 ? "extra_char_u" : "extra_char_s", mon_size, 1);
          end else begin
            mon_front = (i == 0) ? exp_q0[0] : exp_q1[0];
            checkOutput(i == 0 ? "char_u" : "char_s", char_w[i], mon_front);
            if (char_ready) begin
              if (i == 0) void'(exp_q0.pop_front());
              else void'(exp_q1.pop_front());
            end
          end
        end
        if (done_w[i]) begin
          done_seen[i]++;
          mon_size = (i == 0) ? exp_q0.size() : exp_q1.size();
          checkOutput(i == 0 ? "done_after_last_u" : "done_after_last_s", mon_size, 0);
          checkOutput(i == 0 ? "done_valid_low_u" : "done_valid_low_s", valid_w[i], 0);
        end
        prev_pend[i] = valid_w[i] & ~char_ready;
        prev_char[i] = char_w[i];
      end
    end
  end

  // One conversion on both instances. bp = 1 stalls each character for
  // three cycles and fires a stray start mid-stream.
  task automatic applyStimulus(input logic [7:0] v, input bit bp,
                               input int lit_lat_u, input string lit_u,
                               input string lit_s);
    int lat [2];
    int first [2];
    int dcyc [2];
    int nchars [2];
    checkString("model_str_u", model_string(v, 1'b0), lit_u);
    checkString("model_str_s", model_string(v, 1'b1), lit_s);
    lat[0] = model_latency(v, 1'b0);
    lat[1] = model_latency(v, 1'b1);
    checkOutput("model_lat_u", lat[0], lit_lat_u);
    loadModel(v);
    nchars[0] = exp_q0.size();
    nchars[1] = exp_q1.size();
    done_seen[0] = 0;
    done_seen[1] = 0;
    first[0] = -1; first[1] = -1;
    dcyc[0] = -1;  dcyc[1] = -1;
    char_ready = ~bp;
    value = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk);
      #1;
      if (bp) char_ready = ((c % 4) == 3);
      if (bp && c == 9) begin
        start = 1'b1;
        value = 8'd99;
      end else begin
        start = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        if (valid_w[i] && first[i] < 0) first[i] = c;
        if (done_w[i] && dcyc[i] < 0) dcyc[i] = c;
      end
      if (dcyc[0] >= 0 && dcyc[1] >= 0 && c >= dcyc[0] + 2 && c >= dcyc[1] + 2) break;
    end
    start = 1'b0;
    checkOutput("first_valid_u", first[0], lat[0]);
    checkOutput("first_valid_s", first[1], lat[1]);
    checkOutput("done_count_u", done_seen[0], 1);
    checkOutput("done_count_s", done_seen[1], 1);
    if (!bp) begin
      checkOutput("done_latency_u", dcyc[0] - first[0], nchars[0]);
      checkOutput("done_latency_s", dcyc[1] - first[1], nchars[1]);
    end
    checkOutput("left_over_u", exp_q0.size(), 0);
    checkOutput("left_over_s", exp_q1.size(), 0);
    checkOutput("busy_idle", busy_w, 2'b00);
  endtask

  initial begin
    done_seen[0] = 0;
    done_seen[1] = 0;
    prev_pend[0] = 1'b0;
    prev_pend[1] = 1'b0;
    #1;
    checkOutput("rst_busy", busy_w, 2'b00);
    checkOutput("rst_done", done_w, 2'b00);
    checkOutput("rst_valid", valid_w, 2'b00);
    checkOutput("rst_char_u", char_w[0], 8'h00);
    checkOutput("rst_char_s", char_w[1], 8'h00);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus(8'd0,   1'b0, 2, "0",   "0");
    applyStimulus(8'd255, 1'b0, 9, "255", "-1");
    applyStimulus(8'd105, 1'b0, 3, "105", "105");
    applyStimulus(8'd7,   1'b0, 2, "7",   "7");
    applyStimulus(8'hF6,  1'b0, 8, "246", "-10");
    applyStimulus(8'h80,  1'b0, 5, "128", "-128");
    applyStimulus(8'd42,  1'b1, 6, "42",  "42");

    // Abort in the tens digit of 200: the unsigned instance shows its
    // first '0' exactly when it sits in the tens emit state.
    loadModel(8'd200);
    done_seen[0] = 0;
    done_seen[1] = 0;
    char_ready = 1'b1;
    value = 8'd200;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (valid_w[0] && char_w[0] == 8'h30) break;
    end
    checkOutput("reach_tens_u", char_w[0], 8'h30);
    rst = 1'b1;
    #1;
    checkOutput("abort_valid", valid_w, 2'b00);
    checkOutput("abort_busy", busy_w, 2'b00);
    checkOutput("abort_done", done_w, 2'b00);
    checkOutput("abort_char_u", char_w[0], 8'h00);
    checkOutput("abort_char_s", char_w[1], 8'h00);
    exp_q0.delete();
    exp_q1.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_no_done_u", done_seen[0], 0);
    checkOutput("abort_no_done_s", done_seen[1], 0);
    checkOutput("abort_quiet", valid_w, 2'b00);

    applyStimulus(8'd9, 1'b0, 2, "9", "9");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
